// File: rtl/uart_result_arbiter.sv
// Round-robin arbiter that serializes one 32-bit result at a time onto a byte stream.
// Each frame is a tag header byte followed by the result bytes, least significant first.
module uart_result_arbiter #(
  parameter int         NUM_REQ_P      = 3,
  parameter int         RESULT_WIDTH_P = 32,
  parameter logic [7:0] HDR_BASE_P     = 8'hA0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ_P-1:0]                req_valid_i,
  input  logic [NUM_REQ_P*RESULT_WIDTH_P-1:0] req_data_i,
  output logic [NUM_REQ_P-1:0]                req_ready_o,
  output logic [7:0]                          tx_data_o,
  output logic                                tx_valid_o,
  input  logic                                tx_ready_i,
  output logic [NUM_REQ_P-1:0]                grant_o,
  output logic                                busy_o
);

  localparam int BYTES = RESULT_WIDTH_P / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                    state_reg, state_next;
  logic [3:0]                last_reg;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [RESULT_WIDTH_P-1:0] data_reg;
  logic [RESULT_WIDTH_P-1:0] data_in;
  logic [RESULT_WIDTH_P-1:0] req_slice [NUM_REQ_P];
  logic [7:0]                byte_sel [BYTES];
  logic [NUM_REQ_P-1:0]      pick_onehot;
  logic [3:0]                pick, pick_hi, pick_lo;
  logic                      found, found_hi;
  logic                      accept, handshake;
  logic                      tx_valid_next;
  logic [7:0]                tx_data_next;
  logic [NUM_REQ_P-1:0]      grant_next;
  logic                      busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ_P; gi++) begin : g_req
      assign req_slice[gi]   = req_data_i[gi*RESULT_WIDTH_P +: RESULT_WIDTH_P];
      assign pick_onehot[gi] = found && (pick == 4'(gi));
    end
    for (gi = 0; gi < BYTES; gi++) begin : g_byte
      assign byte_sel[gi] = data_reg[gi*8 +: 8];
    end
  endgenerate

  // Lowest valid index above the last grant wins; otherwise wrap to the lowest valid index.
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    found    = 1'b0;
    pick_lo  = '0;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      if (!found_hi && req_valid_i[i] && (4'(i) > last_reg)) begin
        found_hi = 1'b1;
        pick_hi  = 4'(i);
      end
      if (!found && req_valid_i[i]) begin
        found   = 1'b1;
        pick_lo = 4'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    data_in = '0;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      if (pick_onehot[i]) data_in = req_slice[i];
    end
  end

  assign accept    = (state_reg == IDLE) && found;
  assign handshake = tx_valid_o && tx_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      data_reg   <= '0;
      last_reg   <= 4'(NUM_REQ_P - 1);
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      grant_o    <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      tx_valid_o <= tx_valid_next;
      tx_data_o  <= tx_data_next;
      grant_o    <= grant_next;
      busy_o     <= busy_next;
      if (accept) begin
        data_reg <= data_in;
        last_reg <= pick;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = HDR;
      HDR:     if (handshake) state_next = DATA;
      DATA:    if (handshake && (cnt_reg == LAST_BYTE)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is gated by reset so no accept strobe is seen while the arbiter is held in reset.
  always_comb begin
    req_ready_o   = (rst_ni && accept) ? pick_onehot : '0;
    tx_valid_next = tx_valid_o;
    tx_data_next  = tx_data_o;
    grant_next    = grant_o;
    busy_next     = busy_o;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          tx_valid_next = 1'b1;
          tx_data_next  = HDR_BASE_P | {4'b0000, pick};
          grant_next    = pick_onehot;
          busy_next     = 1'b1;
        end
      end
      HDR: begin
        if (handshake) begin
          cnt_next     = '0;
          tx_data_next = byte_sel[0];
        end
      end
      DATA: begin
        if (handshake) begin
          if (cnt_reg == LAST_BYTE) begin
            tx_valid_next = 1'b0;
            tx_data_next  = '0;
            grant_next    = '0;
            busy_next     = 1'b0;
            cnt_next      = '0;
          end else begin
            cnt_next     = cnt_reg + 1'b1;
            tx_data_next = byte_sel[cnt_reg + 1'b1];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_result_arbiter.sv
// Self-checking bench for uart_result_arbiter: a per-cycle frame model built from the
// round-robin and framing rules checks every output while directed and random stimulus runs.
module tb_uart_result_arbiter;
  localparam int N = 3;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;

  uart_result_arbiter #(.NUM_REQ_P(N), .RESULT_WIDTH_P(W), .HDR_BASE_P(8'hA0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: bytes still owed by the current frame, its owner and the last grant.
  int         m_last = N - 1;
  int         m_rem = 0;
  int         m_owner = 0;
  logic [7:0] m_bytes[$];
  logic [7:0] tags[$];
  logic [7:0] obs[$];
  logic [N-1:0] auto_drop = '1;
  int         ready_cnt[N];

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_rem = 0;
    m_last = N - 1;
    m_bytes.delete();
  endtask

  task automatic set_req(input int i, input logic [31:0] d);
    req_data[i*W +: W] = d;
    req_valid[i] = 1'b1;
  endtask

  // One clock: check outputs at the falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic step();
    int pick;
    int c;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_grant;
    logic [31:0] d;
    pick = -1;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
    end else if (m_rem == 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (pick < 0 && req_valid[c]) pick = c;
      end
      exp_ready = '0;
      if (pick >= 0) exp_ready[pick] = 1'b1;
      chk("idle_ready", req_ready, exp_ready);
      chk("idle_tx_valid", tx_valid, 0);
      chk("idle_grant", grant, 0);
      chk("idle_busy", busy, 0);
      if (pick >= 0) begin
        d = req_data[pick*W +: W];
        m_bytes = {8'hA0 | 8'(pick), d[7:0], d[15:8], d[23:16], d[31:24]};
        m_rem = 5;
        m_owner = pick;
        m_last = pick;
        ready_cnt[pick]++;
      end
    end else begin
      exp_grant = '0;
      exp_grant[m_owner] = 1'b1;
      chk("frame_ready", req_ready, 0);
      chk("frame_tx_valid", tx_valid, 1);
      chk("frame_tx_data", tx_data, m_bytes[0]);
      chk("frame_grant", grant, exp_grant);
      chk("frame_busy", busy, 1);
      if (tx_ready) begin
        if (m_rem == 5) tags.push_back(tx_data);
        obs.push_back(tx_data);
        void'(m_bytes.pop_front());
        m_rem--;
      end
    end
    @(posedge clk);
    #1;
    if (pick >= 0 && auto_drop[pick]) req_valid[pick] = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((m_rem != 0 || req_valid != 0) && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'((m_rem != 0) || (req_valid != 0)), 0);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] hdr, input logic [31:0] d);
    chk({tag, "_len"}, obs.size(), 5);
    if (obs.size() == 5) begin
      chk({tag, "_hdr"}, obs[0], hdr);
      chk({tag, "_data"}, {obs[4], obs[3], obs[2], obs[1]}, d);
    end
  endtask

  initial begin
    int n;
    int r1_before;
    int r0_before;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;

    // Single request from requester 1
    tx_ready = 1'b1;
    tags.delete(); obs.delete();
    set_req(1, 32'h12345678);
    drain(20);
    repeat (2) step();
    chk("single_ready_cnt", ready_cnt[1], 1);
    chk_frame("single", 8'hA1, 32'h12345678);

    // Contention from reset
    rst_n = 1'b0;
    model_reset();
    set_req(0, 32'h11111111);
    set_req(1, 32'h22222222);
    set_req(2, 32'h33333333);
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    repeat (2) step();
    rst_n = 1'b1;
    tags.delete(); obs.delete();
    drain(40);
    chk("cont_tags", tags.size(), 3);
    if (tags.size() == 3) begin
      chk("cont_tag0", tags[0], 8'hA0);
      chk("cont_tag1", tags[1], 8'hA1);
      chk("cont_tag2", tags[2], 8'hA2);
    end
    for (int i = 0; i < N; i++) chk("cont_ready_once", ready_cnt[i], 1);

    // Fairness: requesters 0 and 2 held valid
    r1_before = ready_cnt[1];
    auto_drop = 3'b010;
    tags.delete();
    set_req(0, 32'hA5A5A5A5);
    set_req(2, 32'h5A5A5A5A);
    n = 0;
    while (tags.size() < 4 && n < 60) begin step(); n++; end
    chk("fair_timeout", 32'(tags.size() < 4), 0);
    req_valid = '0;
    auto_drop = '1;
    drain(20);
    for (int i = 0; i < 4 && i < tags.size(); i++)
      chk("fair_alternate", tags[i], (i % 2 == 0) ? 8'hA0 : 8'hA2);
    chk("fair_req1_idle", ready_cnt[1], r1_before);

    // Backpressure on the 0x56 byte
    obs.delete();
    set_req(1, 32'h12345678);
    n = 0;
    while (m_rem != 3 && n < 20) begin step(); n++; end
    chk("bp_reach", m_rem, 3);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", tx_valid, 1);
      chk("bp_hold_data", tx_data, 8'h56);
    end
    tx_ready = 1'b1;
    drain(20);
    chk_frame("bp", 8'hA1, 32'h12345678);

    // Asynchronous reset right after the header handshake
    set_req(2, 32'hAABBCCDD);
    n = 0;
    while (m_rem != 4 && n < 20) begin step(); n++; end
    chk("rstmid_reach", m_rem, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_tx_valid", tx_valid, 0);
    chk("rstmid_grant", grant, 0);
    chk("rstmid_busy", busy, 0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    tags.delete(); obs.delete();
    set_req(2, 32'h01020304);
    drain(20);
    chk_frame("rstmid", 8'hA2, 32'h01020304);

    // Reset again mid-frame; requester 0 regains first priority
    set_req(2, 32'h0BADF00D);
    n = 0;
    while (m_rem != 4 && n < 20) begin step(); n++; end
    #2 rst_n = 1'b0;
    model_reset();
    set_req(0, 32'h0000AAAA);
    set_req(2, 32'h0000BBBB);
    repeat (2) step();
    rst_n = 1'b1;
    tags.delete();
    drain(30);
    chk("prio_tags", tags.size(), 2);
    if (tags.size() == 2) begin
      chk("prio_tag0", tags[0], 8'hA0);
      chk("prio_tag1", tags[1], 8'hA2);
    end

    // Data changes after accept are not transmitted
    obs.delete();
    r0_before = ready_cnt[0];
    set_req(0, 32'hCAFEBABE);
    n = 0;
    while (ready_cnt[0] == r0_before && n < 10) begin step(); n++; end
    req_data[0 +: W] = 32'hDEADBEEF;
    drain(20);
    chk_frame("mutate", 8'hA0, 32'hCAFEBABE);

    // Random traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(3) == 0) set_req(i, $urandom());
      tx_ready = 1'($urandom_range(1));
      step();
    end
    tx_ready = 1'b1;
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
